// File: rtl/apu_package.sv
// Shared APU cluster definitions: multiplier interface widths, operator codes
// and the per-core integer-multiply request bundle.
package apu_package;

    localparam int unsigned WOP_INT_MULT      = 2;
    localparam int unsigned DSP_WIDTH         = 32;
    localparam int unsigned NDSFLAGS_INT_MULT = 2;
    localparam int unsigned WAPUTAG           = 8;

    localparam logic [WOP_INT_MULT-1:0] OP_MUL = 2'd0;
    localparam logic [WOP_INT_MULT-1:0] OP_MAC = 2'd1;

    typedef struct packed {
        logic [WOP_INT_MULT-1:0]      op;
        logic [DSP_WIDTH-1:0]         opa;
        logic [DSP_WIDTH-1:0]         opb;
        logic [DSP_WIDTH-1:0]         opc;
        logic [NDSFLAGS_INT_MULT-1:0] flags;
        logic [WAPUTAG-1:0]           tag;
    } int_mult_req_t;

endpackage

// File: rtl/rr_arb_ptr.sv
// Round-robin arbiter: picks the first requester at or after the pointer and
// moves the pointer just past the winner whenever a grant is issued.
module rr_arb_ptr #(
    parameter int unsigned NCORES    = 4,
    parameter int unsigned CID_WIDTH = $clog2(NCORES)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NCORES-1:0]    req_i,
    input  logic                 en_i,
    output logic [NCORES-1:0]    gnt_o,
    output logic [CID_WIDTH-1:0] cid_o,
    output logic                 valid_o
);

    logic [CID_WIDTH-1:0] ptr;

    // Search NCORES slots starting at the pointer, wrapping explicitly so a
    // non power-of-two core count never produces an out-of-range index.
    always_comb begin
        int unsigned          idx;
        logic [CID_WIDTH-1:0] idx_c;
        logic                 found;
        gnt_o = '0;
        cid_o = '0;
        found = 1'b0;
        idx   = 0;
        idx_c = '0;
        if (en_i) begin
            for (int unsigned k = 0; k < NCORES; k++) begin
                idx = 32'(ptr) + k;
                if (idx >= NCORES) begin
                    idx = idx - NCORES;
                end
                idx_c = CID_WIDTH'(idx);
                if (!found && req_i[idx_c]) begin
                    found        = 1'b1;
                    gnt_o[idx_c] = 1'b1;
                    cid_o        = idx_c;
                end
            end
        end
        valid_o = found;
    end

    // Advance the pointer past the granted core; hold it when nothing is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (valid_o) begin
            ptr <= (cid_o == CID_WIDTH'(NCORES - 1)) ? '0 : cid_o + 1'b1;
        end
    end

endmodule

// File: rtl/int_mult_sched.sv
// Shares one integer multiplier between NCORES cores: round-robin issue into
// an S1 register feeding the multiplier, S2 result register returned to the
// owning core with a valid/ack handshake. An un-acked result stalls the pipe.
module int_mult_sched
    import apu_package::*;
#(
    parameter int unsigned NCORES    = 4,
    parameter int unsigned TAG_WIDTH = WAPUTAG,
    parameter int unsigned CID_WIDTH = $clog2(NCORES)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NCORES-1:0]                     req_i,
    output logic [NCORES-1:0]                     gnt_o,
    input  logic [NCORES*WOP_INT_MULT-1:0]        op_i,
    input  logic [NCORES*DSP_WIDTH-1:0]           opa_i,
    input  logic [NCORES*DSP_WIDTH-1:0]           opb_i,
    input  logic [NCORES*DSP_WIDTH-1:0]           opc_i,
    input  logic [NCORES*NDSFLAGS_INT_MULT-1:0]   flags_i,
    input  logic [NCORES*TAG_WIDTH-1:0]           tag_i,
    output logic                                  mult_en_o,
    output logic [WOP_INT_MULT-1:0]               mult_op_o,
    output logic [DSP_WIDTH-1:0]                  mult_opa_o,
    output logic [DSP_WIDTH-1:0]                  mult_opb_o,
    output logic [DSP_WIDTH-1:0]                  mult_opc_o,
    output logic [NDSFLAGS_INT_MULT-1:0]          mult_flags_o,
    output logic [CID_WIDTH+TAG_WIDTH-1:0]        mult_tag_o,
    input  logic [DSP_WIDTH-1:0]                  mult_res_i,
    input  logic [CID_WIDTH+TAG_WIDTH-1:0]        mult_tag_i,
    input  logic                                  mult_valid_i,
    output logic [DSP_WIDTH-1:0]                  res_o,
    output logic [TAG_WIDTH-1:0]                  res_tag_o,
    output logic [NCORES-1:0]                     res_valid_o,
    input  logic [NCORES-1:0]                     res_ack_i
);

    logic                           s1_valid;
    int_mult_req_t                  s1_req;
    logic [CID_WIDTH-1:0]           s1_cid;
    logic                           s2_valid;
    logic [DSP_WIDTH-1:0]           s2_res;
    logic [CID_WIDTH+TAG_WIDTH-1:0] s2_tag;
    logic [CID_WIDTH-1:0]           s2_cid;
    logic                           s2_free;
    logic                           s1_adv;
    logic                           s1_free;
    logic [CID_WIDTH-1:0]           arb_cid;
    logic                           arb_valid;
    int_mult_req_t                  sel;

    assign s2_cid  = s2_tag[TAG_WIDTH +: CID_WIDTH];
    assign s2_free = !s2_valid || res_ack_i[s2_cid];
    assign s1_adv  = s1_valid && s2_free;
    assign s1_free = !s1_valid || s1_adv;

    rr_arb_ptr #(
        .NCORES    (NCORES),
        .CID_WIDTH (CID_WIDTH)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .en_i    (s1_free),
        .gnt_o   (gnt_o),
        .cid_o   (arb_cid),
        .valid_o (arb_valid)
    );

    // Mux the winning core's request bundle.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            if (CID_WIDTH'(i) == arb_cid) begin
                sel.op    = op_i[i*WOP_INT_MULT +: WOP_INT_MULT];
                sel.opa   = opa_i[i*DSP_WIDTH +: DSP_WIDTH];
                sel.opb   = opb_i[i*DSP_WIDTH +: DSP_WIDTH];
                sel.opc   = opc_i[i*DSP_WIDTH +: DSP_WIDTH];
                sel.flags = flags_i[i*NDSFLAGS_INT_MULT +: NDSFLAGS_INT_MULT];
                sel.tag   = WAPUTAG'(tag_i[i*TAG_WIDTH +: TAG_WIDTH]);
            end
        end
    end

    // S1 issue register: reloads whenever it is free; a grant is the acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
            s1_cid   <= '0;
        end else if (s1_free) begin
            s1_valid <= arb_valid;
            if (arb_valid) begin
                s1_req <= sel;
                s1_cid <= arb_cid;
            end
        end
    end

    // S2 result register: ack and a new capture in one cycle reload with no bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_tag   <= '0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_res   <= mult_res_i;
            s2_tag   <= mult_tag_i;
        end else if (s2_free) begin
            s2_valid <= 1'b0;
        end
    end

    assign mult_en_o    = s1_valid;
    assign mult_op_o    = s1_req.op;
    assign mult_opa_o   = s1_req.opa;
    assign mult_opb_o   = s1_req.opb;
    assign mult_opc_o   = s1_req.opc;
    assign mult_flags_o = s1_req.flags;
    assign mult_tag_o   = {s1_cid, TAG_WIDTH'(s1_req.tag)};

    assign res_o       = s2_res;
    assign res_tag_o   = s2_tag[TAG_WIDTH-1:0];
    assign res_valid_o = {{(NCORES-1){1'b0}}, s2_valid} << s2_cid;

    // The multiplier is combinational: a result must accompany every enable.
    assert property (@(posedge clk_i) disable iff (!rst_ni) s1_valid |-> mult_valid_i);

endmodule

// File: tb/tb_int_mult_sched.sv
// Bench for int_mult_sched: directed scenarios plus randomized traffic checked
// against a queue-based reference of issued operations.
module tb_int_mult_sched;
    import apu_package::*;

    localparam int N  = 4;
    localparam int TW = WAPUTAG;
    localparam int CW = 2;
    localparam int W  = DSP_WIDTH;
    localparam int OW = WOP_INT_MULT;
    localparam int FW = NDSFLAGS_INT_MULT;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N-1:0]      gnt;
    logic [N*OW-1:0]   op;
    logic [N*W-1:0]    opa, opb, opc;
    logic [N*FW-1:0]   flags;
    logic [N*TW-1:0]   tag;
    logic              mult_en;
    logic [OW-1:0]     mult_op;
    logic [W-1:0]      mult_opa, mult_opb, mult_opc;
    logic [FW-1:0]     mult_flags;
    logic [CW+TW-1:0]  mult_tag_out;
    logic [W-1:0]      mult_res;
    logic [CW+TW-1:0]  mult_tag_ret;
    logic              mult_valid;
    logic [W-1:0]      res;
    logic [TW-1:0]     res_tag;
    logic [N-1:0]      res_valid;
    logic [N-1:0]      ack;

    always #5 clk = ~clk;

    int_mult_sched #(.NCORES(N), .TAG_WIDTH(TW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .gnt_o        (gnt),
        .op_i         (op),
        .opa_i        (opa),
        .opb_i        (opb),
        .opc_i        (opc),
        .flags_i      (flags),
        .tag_i        (tag),
        .mult_en_o    (mult_en),
        .mult_op_o    (mult_op),
        .mult_opa_o   (mult_opa),
        .mult_opb_o   (mult_opb),
        .mult_opc_o   (mult_opc),
        .mult_flags_o (mult_flags),
        .mult_tag_o   (mult_tag_out),
        .mult_res_i   (mult_res),
        .mult_tag_i   (mult_tag_ret),
        .mult_valid_i (mult_valid),
        .res_o        (res),
        .res_tag_o    (res_tag),
        .res_valid_o  (res_valid),
        .res_ack_i    (ack)
    );

    // Stand-in multiplier: MUL = a*b, MAC = a*b+c, flags added so their routing is visible.
    function automatic logic [W-1:0] mmul(logic [OW-1:0] o, logic [W-1:0] a, logic [W-1:0] b,
                                          logic [W-1:0] c, logic [FW-1:0] f);
        logic [W-1:0] r;
        r = a * b;
        if (o == OP_MAC) r = r + c;
        return r + W'(f);
    endfunction

    assign mult_res     = mmul(mult_op, mult_opa, mult_opb, mult_opc, mult_flags);
    assign mult_tag_ret = mult_tag_out;
    assign mult_valid   = mult_en;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: ops accepted but not yet acked, oldest first.
    typedef struct {
        int           core;
        logic [TW-1:0] t;
        logic [W-1:0]  r;
        int           gcyc;
    } exp_t;

    exp_t q[$];
    int   ptr_m;
    int   waitc[N];
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    task automatic model_clear();
        q.delete();
        ptr_m = 0;
        for (int c = 0; c < N; c++) waitc[c] = 0;
    endtask

    task automatic monitor();
        bit   s1_free_m;
        bit   exp_any;
        int   g;
        exp_t e;
        check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
        // Two ops in flight fill both stages; only acking the oldest frees issue.
        s1_free_m = (q.size() < 2) || ack[q[0].core];
        exp_any   = (req != '0) && s1_free_m;
        check("gnt_any", 64'(gnt != '0), 64'(exp_any));

        if (res_valid != '0) begin
            if (q.size() == 0) begin
                check("res_spurious", 64'(res_valid), 64'd0);
            end else begin
                check("res_owner", 64'(res_valid), 64'(N'(1) << q[0].core));
                check("res_value", 64'(res), 64'(q[0].r));
                check("res_tag",   64'(res_tag), 64'(q[0].t));
                if (ack[q[0].core]) void'(q.pop_front());
            end
        end else if (q.size() > 0) begin
            check("res_latency", 64'((cyc - q[0].gcyc) < 2), 64'd1);
        end

        if (gnt != '0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ptr_m + k) % N;
                if (g < 0 && req[c]) g = c;
            end
            if (g < 0) g = 0;
            check("gnt_idx", 64'(gnt), 64'(N'(1) << g));
            for (int c = 0; c < N; c++) begin
                if (c == g) begin
                    waitc[c] = 0;
                end else if (req[c]) begin
                    waitc[c]++;
                    check("fairness", 64'(waitc[c] < N), 64'd1);
                end else begin
                    waitc[c] = 0;
                end
            end
            e.core = g;
            e.t    = tag[g*TW +: TW];
            e.r    = mmul(op[g*OW +: OW], opa[g*W +: W], opb[g*W +: W], opc[g*W +: W], flags[g*FW +: FW]);
            e.gcyc = cyc;
            q.push_back(e);
            ptr_m = (g + 1) % N;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (mon_en) monitor();
    end

    // Called at a negedge: cores that were granted drop their request after the edge.
    task automatic finish_cycle();
        logic [N-1:0] g;
        g = gnt;
        @(posedge clk);
        #1;
        req = req & ~g;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        req    = '0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        mon_en = 1'b1;
    endtask

    task automatic set_core(int c, logic [OW-1:0] o, logic [W-1:0] a, logic [W-1:0] b,
                            logic [W-1:0] cc, logic [FW-1:0] f, logic [TW-1:0] t);
        op[c*OW +: OW]    = o;
        opa[c*W +: W]     = a;
        opb[c*W +: W]     = b;
        opc[c*W +: W]     = cc;
        flags[c*FW +: FW] = f;
        tag[c*TW +: TW]   = t;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        ack   = '0;
        op    = '0;
        opa   = '0;
        opb   = '0;
        opc   = '0;
        flags = '0;
        tag   = '0;
        model_clear();
        #12;
        check("rst_mult_en",   64'(mult_en), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_gnt",       64'(gnt), 64'd0);
        check("rst_mult_tag",  64'(mult_tag_out), 64'd0);
        check("rst_res",       64'(res), 64'd0);
        check("rst_res_tag",   64'(res_tag), 64'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single request from core 1: grant, issue, result on consecutive cycles.
        for (int c = 0; c < N; c++) set_core(c, OP_MUL, W'(c + 10), W'(c + 20), '0, '0, TW'(c));
        set_core(1, OP_MUL, 32'd3, 32'd5, 32'd0, 2'd0, 8'h2A);
        ack = '1;
        req = 4'b0010;
        @(negedge clk);
        check("t1_gnt", 64'(gnt), 64'b0010);
        finish_cycle();
        @(negedge clk);
        check("t1_mult_en",  64'(mult_en), 64'd1);
        check("t1_mult_tag", 64'(mult_tag_out), 64'h12A);
        finish_cycle();
        @(negedge clk);
        check("t1_res_valid", 64'(res_valid), 64'b0010);
        check("t1_res",       64'(res), 64'd15);
        check("t1_res_tag",   64'(res_tag), 64'h2A);
        finish_cycle();
        next_cycle();

        // All cores request continuously with acks high: 1 op per cycle, in order.
        do_reset();
        for (int c = 0; c < N; c++) set_core(c, OP_MAC, W'(c + 2), W'(7), W'(c), FW'(c), TW'(8'h40 + c));
        ack = '1;
        for (int k = 0; k < 8; k++) begin
            req = '1;
            @(negedge clk);
            check("t2_gnt", 64'(gnt), 64'(N'(1) << (k % N)));
            if (k >= 2) check("t2_res_valid", 64'(res_valid), 64'(N'(1) << ((k - 2) % N)));
            finish_cycle();
        end
        req = '0;
        repeat (3) next_cycle();

        // Core 2 result held un-acked while cores 0 and 3 request.
        do_reset();
        ack = 4'b1011;
        req = 4'b0100;
        @(negedge clk);
        check("t3_gnt2", 64'(gnt), 64'b0100);
        finish_cycle();
        req = 4'b1001;
        @(negedge clk);
        check("t3_gnt3", 64'(gnt), 64'b1000);
        finish_cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_stall_gnt", 64'(gnt), 64'd0);
            check("t3_stall_res", 64'(res_valid), 64'b0100);
            check("t3_stall_val", 64'(res), 64'(mmul(OP_MAC, 32'd4, 32'd7, 32'd2, 2'd2)));
            finish_cycle();
        end
        ack = '1;
        @(negedge clk);
        check("t3_pop_res", 64'(res_valid), 64'b0100);
        check("t3_pop_gnt", 64'(gnt), 64'b0001);
        finish_cycle();
        @(negedge clk);
        check("t3_res3", 64'(res_valid), 64'b1000);
        finish_cycle();
        @(negedge clk);
        check("t3_res0", 64'(res_valid), 64'b0001);
        finish_cycle();
        next_cycle();

        // Pointer at 3 with only core 1 requesting, then cores 1 and 2.
        do_reset();
        ack = '1;
        req = 4'b0100;
        next_cycle();
        req = 4'b0010;
        @(negedge clk);
        check("t4_gnt1", 64'(gnt), 64'b0010);
        finish_cycle();
        req = 4'b0110;
        @(negedge clk);
        check("t4_gnt2", 64'(gnt), 64'b0100);
        finish_cycle();
        @(negedge clk);
        check("t4_gnt1b", 64'(gnt), 64'b0010);
        finish_cycle();
        repeat (3) next_cycle();

        // Asynchronous reset with both stages occupied.
        do_reset();
        ack = '0;
        req = '1;
        repeat (3) next_cycle();
        req = '0;
        @(negedge clk);
        check("t5_pre_en",  64'(mult_en), 64'd1);
        check("t5_pre_res", 64'(res_valid), 64'b0001);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("t5_rst_en",  64'(mult_en), 64'd0);
        check("t5_rst_res", 64'(res_valid), 64'd0);
        check("t5_rst_gnt", 64'(gnt), 64'd0);
        check("t5_rst_opa", 64'(mult_opa), 64'd0);
        check("t5_rst_val", 64'(res), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        mon_en = 1'b1;
        ack = '1;
        req = 4'b1000;
        @(negedge clk);
        check("t5_gnt3", 64'(gnt), 64'b1000);
        finish_cycle();
        repeat (3) next_cycle();

        // Randomized traffic against the reference queue.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) begin
                if (!req[c]) req[c] = ($urandom_range(0, 2) == 0);
                set_core(c, OW'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                         W'($urandom), FW'($urandom), TW'($urandom));
                ack[c] = ($urandom_range(0, 3) != 0);
            end
            next_cycle();
        end
        req = '0;
        ack = '1;
        repeat (6) next_cycle();
        check("drain_empty", 64'(q.size()), 64'd0);
        check("drain_idle",  64'(res_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
